press_arbiter: RTL and testbench

PRESS_ARBITER -- requirements
Module: press_arbiter

---
 rtl/tow_pkg.sv | 14 +
 rtl/pb_debounce.sv | 25 ++
 rtl/press_arbiter.sv | 67 ++++++
 tb/tb_press_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/tow_pkg.sv
// tow_pkg: shared arbiter state encoding and width helpers
package tow_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, LATCHED} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic logic [3:0] lsb16(input logic [15:0] v);
    lsb16 = '0;
    for (int i = 15; i >= 0; i--) if (v[i]) lsb16 = 4'(i);
  endfunction
endpackage

// File: rtl/pb_debounce.sv
// pb_debounce: 2-flop synchroniser, stable-count debouncer and rising-edge press pulse
module pb_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pb,
  output logic press
);
  logic s1, s2, deb, deb_q;
  logic [7:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {s1, s2, deb, deb_q, cnt} <= '0;
    else begin
      s1 <= pb;
      s2 <= s1;
      deb_q <= deb;
      if (s2 == deb) cnt <= '0;
      else if (cnt == 8'(DEB_CYCLES - 1)) begin
        deb <= s2;
        cnt <= '0;
      end else cnt <= cnt + 8'd1;
    end
  assign press = deb & ~deb_q;
endmodule

// File: rtl/press_arbiter.sv
// press_arbiter: debounced first-press arbiter with tie detection.
// Define PRESS_ARBITER_FALSE_START_EN to add sticky false-start (foul) tracking.
module press_arbiter import tow_pkg::*; #(
  parameter int N_PLAYERS = 2,
  parameter int DEB_CYCLES = 4,
  localparam int IDX_W = clog2(N_PLAYERS) > 1 ? clog2(N_PLAYERS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_PLAYERS-1:0] pb,
  input  logic                 arm,
  input  logic                 clear,
  output logic                 armed,
  output logic                 push,
  output logic [N_PLAYERS-1:0] hit,
  output logic                 tie,
  output logic [IDX_W-1:0]     winner
`ifdef PRESS_ARBITER_FALSE_START_EN
  ,
  output logic [N_PLAYERS-1:0] foul
`endif
);
  state_t state, nxt;
  logic [N_PLAYERS-1:0] press, elig;
  logic go;
  for (genvar g = 0; g < N_PLAYERS; g++) begin : g_deb
    pb_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk(clk), .rst_n(rst_n), .pb(pb[g]), .press(press[g])
    );
  end
`ifdef PRESS_ARBITER_FALSE_START_EN
  assign elig = press & ~foul;
  // presses in IDLE are false starts; any clear out of a live round forgives them
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) foul <= '0;
    else if (clear && state != IDLE) foul <= '0;
    else if (state == IDLE) foul <= foul | press;
`else
  assign elig = press;
`endif
  assign go = |elig;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = state == IDLE  ? (arm && !clear ? ARMED : IDLE) :
          state == ARMED ? (clear ? IDLE : go ? LATCHED : ARMED) :
                           (clear ? IDLE : LATCHED);
  always_comb begin
    armed = state == ARMED;
    push = state == LATCHED;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hit <= '0;
      tie <= 1'b0;
      winner <= '0;
    end else if (state == ARMED && nxt == LATCHED) begin
      hit <= elig;
      tie <= |(elig & (elig - N_PLAYERS'(1)));
      winner <= IDX_W'(lsb16(16'(elig)));
    end else if (state == LATCHED && nxt == IDLE) begin
      hit <= '0;
      tie <= 1'b0;
      winner <= '0;
    end
endmodule

// File: tb/tb_press_arbiter.sv
// tb_press_arbiter: directed scoreboard bench for a 2-player and a 4-player arbiter
module tb_press_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic arm2 = 1'b0, clear2 = 1'b0, arm4 = 1'b0, clear4 = 1'b0;
  logic [1:0] pb2 = '0;
  logic [3:0] pb4 = '0;
  logic armed2, push2, tie2, winner2, armed4, push4, tie4;
  logic [1:0] hit2, winner4, foul2;
  logic [3:0] hit4, foul4;
  int cyc = 0, errors = 0, checks = 0;
  typedef struct {logic [3:0] hit; logic tie; logic [1:0] win; int cyc;} exp_t;
  exp_t q2[$], q4[$];
  logic p2q = 1'b0, p4q = 1'b0;

  press_arbiter #(.N_PLAYERS(2), .DEB_CYCLES(4)) u2 (
    .clk(clk), .rst_n(rst_n), .pb(pb2), .arm(arm2), .clear(clear2),
    .armed(armed2), .push(push2), .hit(hit2), .tie(tie2), .winner(winner2)
`ifdef PRESS_ARBITER_FALSE_START_EN
    , .foul(foul2)
`endif
  );
  press_arbiter #(.N_PLAYERS(4), .DEB_CYCLES(4)) u4 (
    .clk(clk), .rst_n(rst_n), .pb(pb4), .arm(arm4), .clear(clear4),
    .armed(armed4), .push(push4), .hit(hit4), .tie(tie4), .winner(winner4)
`ifdef PRESS_ARBITER_FALSE_START_EN
    , .foul(foul4)
`endif
  );
`ifndef PRESS_ARBITER_FALSE_START_EN
  assign foul2 = '0;
  assign foul4 = '0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp2(input logic [3:0] h, input logic t, input logic [1:0] w, input int c);
    exp_t e;
    e = '{h, t, w, c};
    q2.push_back(e);
  endtask

  task automatic exp4(input logic [3:0] h, input logic t, input logic [1:0] w, input int c);
    exp_t e;
    e = '{h, t, w, c};
    q4.push_back(e);
  endtask

  task automatic idle2(input string tag);
    chk({tag, ".u2.armed"}, armed2, 0);
    chk({tag, ".u2.push"}, push2, 0);
    chk({tag, ".u2.hit"}, hit2, 0);
    chk({tag, ".u2.tie"}, tie2, 0);
    chk({tag, ".u2.winner"}, winner2, 0);
    chk({tag, ".u2.foul"}, foul2, 0);
  endtask

  task automatic idle4(input string tag);
    chk({tag, ".u4.armed"}, armed4, 0);
    chk({tag, ".u4.push"}, push4, 0);
    chk({tag, ".u4.hit"}, hit4, 0);
    chk({tag, ".u4.tie"}, tie4, 0);
    chk({tag, ".u4.winner"}, winner4, 0);
    chk({tag, ".u4.foul"}, foul4, 0);
  endtask

  always @(negedge clk) begin
    if (push2 && !p2q) begin
      if (q2.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL u2.unexpected_push: got push=1 expected none (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q2.pop_front();
        chk("mon.u2.hit", {2'b00, hit2}, e.hit);
        chk("mon.u2.tie", tie2, e.tie);
        chk("mon.u2.winner", winner2, e.win);
        chk("mon.u2.push_cycle", cyc, e.cyc);
      end
    end
    if (push4 && !p4q) begin
      if (q4.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL u4.unexpected_push: got push=1 expected none (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q4.pop_front();
        chk("mon.u4.hit", hit4, e.hit);
        chk("mon.u4.tie", tie4, e.tie);
        chk("mon.u4.winner", winner4, e.win);
        chk("mon.u4.push_cycle", cyc, e.cyc);
      end
    end
    p2q <= push2;
    p4q <= push4;
  end

  initial begin
    tick(3);
    idle2("reset");
    idle4("reset");
    rst_n = 1'b1;
    tick(2);
    // clean single press on the 2-player unit: push 7 edges after the raw edge
    arm2 = 1'b1; tick(1); arm2 = 1'b0;
    chk("clean.armed", armed2, 1);
    tick(2);
    pb2 = 2'b10;
    exp2(4'b0010, 1'b0, 2'd1, cyc + 7);
    tick(12);
    chk("clean.push_held", push2, 1);
    pb2 = '0;
    clear2 = 1'b1; tick(1); clear2 = 1'b0;
    idle2("clean.clear");
    tick(8);
    // simultaneous presses on the 4-player unit
    arm4 = 1'b1; tick(1); arm4 = 1'b0;
    tick(2);
    pb4 = 4'b1100;
    exp4(4'b1100, 1'b1, 2'd2, cyc + 7);
    tick(12);
    chk("tie.push_held", push4, 1);
    pb4 = '0;
    clear4 = 1'b1; tick(1); clear4 = 1'b0;
    idle4("tie.clear");
    tick(8);
    // bouncing button: no press until the level holds for the full window
    arm4 = 1'b1; tick(1); arm4 = 1'b0;
    tick(2);
    for (int i = 0; i < 10; i++) begin
      pb4[0] = ~i[0];
      tick(2);
    end
    chk("bounce.no_push", push4, 0);
    chk("bounce.still_armed", armed4, 1);
    pb4[0] = 1'b1;
    exp4(4'b0001, 1'b0, 2'd0, cyc + 7);
    tick(12);
    chk("bounce.push_held", push4, 1);
    pb4 = '0;
    clear4 = 1'b1; tick(1); clear4 = 1'b0;
    tick(8);
    // button held before arm is not a press
    pb2 = 2'b01;
    tick(10);
    arm2 = 1'b1; tick(1); arm2 = 1'b0;
    tick(3);
    chk("held.no_latch", push2, 0);
    pb2 = 2'b11;
    exp2(4'b0010, 1'b0, 2'd1, cyc + 7);
    tick(12);
    chk("held.winner", winner2, 1);
    clear2 = 1'b1; tick(1); clear2 = 1'b0;
    idle2("held.clear");
    pb2 = '0;
    tick(8);
    // asynchronous reset in ARMED and in LATCHED
    arm4 = 1'b1; tick(1); arm4 = 1'b0;
    chk("rst_armed.pre", armed4, 1);
    rst_n = 1'b0;
    #1;
    idle4("rst_armed");
    tick(2);
    rst_n = 1'b1;
    tick(2);
    arm2 = 1'b1; tick(1); arm2 = 1'b0;
    tick(1);
    pb2 = 2'b01;
    exp2(4'b0001, 1'b0, 2'd0, cyc + 7);
    tick(10);
    chk("rst_latched.pre", push2, 1);
    pb2 = '0;
    rst_n = 1'b0;
    #1;
    idle2("rst_latched");
    tick(2);
    rst_n = 1'b1;
    tick(2);
    // clear wins over arm
    arm2 = 1'b1; clear2 = 1'b1; tick(1); arm2 = 1'b0; clear2 = 1'b0;
    chk("arm_clear.armed", armed2, 0);
    chk("arm_clear.push", push2, 0);
    tick(2);
`ifdef PRESS_ARBITER_FALSE_START_EN
    pb2 = 2'b01;
    tick(10);
    chk("foul.set", foul2, 2'b01);
    pb2 = '0;
    tick(8);
    arm2 = 1'b1; tick(1); arm2 = 1'b0;
    pb2 = 2'b01;
    tick(12);
    chk("foul.no_latch", push2, 0);
    chk("foul.still_armed", armed2, 1);
    pb2 = 2'b11;
    exp2(4'b0010, 1'b0, 2'd1, cyc + 7);
    tick(12);
    chk("foul.push_held", push2, 1);
    clear2 = 1'b1; tick(1); clear2 = 1'b0;
    chk("foul.cleared", foul2, 2'b00);
    pb2 = '0;
    tick(8);
`endif
    tick(3);
    chk("u2.queue_drained", q2.size(), 0);
    chk("u4.queue_drained", q4.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
